pdm_mic_if: RTL and testbench

//  PDM microphone front end. Sits between the pads (pdm_data_i, pdm_clk_o, vad_i)
//  and the decimating DFE inside wakey_wakey. Generates the mic clock only while
//  the external VAD is asserted and discards the mic start-up transient.

---
 rtl/wakey_wakey_pkg.sv | 15 +
 rtl/sync_2ff.sv | 22 ++
 rtl/pdm_mic_if.sv | 125 ++++++++++++
 tb/tb_pdm_mic_if.sv | 134 +++++++++++++
 4 files changed

// File: rtl/wakey_wakey_pkg.sv
// Shared definitions for the wakey_wakey audio front end: PDM interface
// state encodings and the default rate constants also used by the DFE.
package wakey_wakey_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    STOP   = 2'd3
  } pdm_state_e;

  localparam int unsigned PDM_CLK_DIV       = 8;
  localparam int unsigned PDM_WARMUP_CYCLES = 1024;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First stage may go metastable; second stage gives a settled level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pdm_mic_if.sv
// PDM microphone front end: gates the mic clock on external VAD, discards
// the mic start-up transient, and emits one sampled bit per mic-clock period.
module pdm_mic_if
  import wakey_wakey_pkg::*;
#(
  parameter int unsigned CLK_DIV       = PDM_CLK_DIV,
  parameter int unsigned SAMPLE_PHASE  = 7,
  parameter int unsigned WARMUP_CYCLES = PDM_WARMUP_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pdm_data_i,
  input  logic vad_i,
  output logic pdm_clk_o,
  output logic pdm_bit_o,
  output logic pdm_valid_o,
  output logic active_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned WU_W  = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] SAMPLE_AT = DIV_W'(SAMPLE_PHASE);
  localparam logic [WU_W-1:0]  WU_LAST   = WU_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  if ((CLK_DIV % 2) != 0 || CLK_DIV < 4 || SAMPLE_PHASE >= CLK_DIV) begin : g_bad_params
    $error("pdm_mic_if: CLK_DIV must be even and >= 4, SAMPLE_PHASE must be < CLK_DIV");
  end

  logic vad_s;
  logic dat_s;

  sync_2ff u_sync_vad (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (vad_i),
    .q     (vad_s)
  );

  sync_2ff u_sync_dat (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (pdm_data_i),
    .q     (dat_s)
  );

  pdm_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WU_W-1:0]  wu_q, wu_d;
  logic             period_end;
  logic             clk_d;
  logic             capture;

  assign period_end = (div_q == DIV_LAST);

  // Next-state, counter and output-decode logic.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    wu_d    = wu_q;
    clk_d   = 1'b0;
    capture = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (vad_s) state_d = (WARMUP_CYCLES > 0) ? WARMUP : RUN;
      end
      WARMUP: begin
        if (!vad_s)                          state_d = STOP;
        else if (period_end && wu_q == WU_LAST) state_d = RUN;
      end
      RUN: begin
        if (!vad_s) state_d = STOP;
      end
      STOP: begin
        if (period_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh start holds div at 0 for its first cycle so the first high
    // phase is full length; the clock is decoded from next-state values so
    // the registered pin lines up exactly with the period counter.
    if (state_q == IDLE || state_d == IDLE) div_d = '0;
    else if (period_end)                     div_d = '0;
    else                                     div_d = div_q + 1'b1;

    if (state_q != WARMUP)                 wu_d = '0;
    else if (period_end && wu_q != '1)     wu_d = wu_q + 1'b1;

    clk_d   = (state_d != IDLE) && (div_d < DIV_HALF);
    capture = (state_q == RUN) && (div_q == SAMPLE_AT);
  end

  // FSM state and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      wu_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      wu_q    <= wu_d;
    end
  end

  // Registered outputs: glitch-free mic clock, capture strobe and activity flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pdm_clk_o   <= 1'b0;
      pdm_bit_o   <= 1'b0;
      pdm_valid_o <= 1'b0;
      active_o    <= 1'b0;
    end else begin
      pdm_clk_o   <= clk_d;
      pdm_valid_o <= capture;
      active_o    <= (state_d != IDLE);
      if (capture) pdm_bit_o <= dat_s;
    end
  end

endmodule

// File: tb/tb_pdm_mic_if.sv
// Directed bench for pdm_mic_if (CLK_DIV=4, SAMPLE_PHASE=3; warm-up 3 and 0).
module tb_pdm_mic_if;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic vad      = 1'b0;
  logic vad0     = 1'b0;
  logic pdm_data = 1'b0;

  logic pclk, pbit, pvalid, pact;
  logic pclk0, pbit0, pvalid0, pact0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] pat = 32'h9E37_5A1C;
  logic        dat_hist [0:127];

  pdm_mic_if #(.CLK_DIV(4), .SAMPLE_PHASE(3), .WARMUP_CYCLES(3)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .pdm_data_i  (pdm_data),
    .vad_i       (vad),
    .pdm_clk_o   (pclk),
    .pdm_bit_o   (pbit),
    .pdm_valid_o (pvalid),
    .active_o    (pact)
  );

  pdm_mic_if #(.CLK_DIV(4), .SAMPLE_PHASE(3), .WARMUP_CYCLES(0)) dut0 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .pdm_data_i  (pdm_data),
    .vad_i       (vad0),
    .pdm_clk_o   (pclk0),
    .pdm_bit_o   (pbit0),
    .pdm_valid_o (pvalid0),
    .active_o    (pact0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // t counts edges after the moment vad was driven high (t=0, just after an edge).
  // Mic clock rises at t=3, period 4; strobes at first_valid + 4k; bit = data driven at t-3.
  task automatic run_seq(input bit sel0, input int last_t, input int drop_t,
                         input int idle_t, input int first_valid, input string name);
    logic c, v, a, b;
    logic ec, ev, ea;
    dat_hist[0] = pat[0];
    pdm_data    = dat_hist[0];
    for (int t = 1; t <= last_t; t++) begin
      step();
      c = sel0 ? pclk0   : pclk;
      v = sel0 ? pvalid0 : pvalid;
      a = sel0 ? pact0   : pact;
      b = sel0 ? pbit0   : pbit;
      ec = (t >= 3) && (t < idle_t) && (((t - 3) % 4) < 2);
      ev = (t >= first_valid) && (t < idle_t) && (((t - first_valid) % 4) == 0);
      ea = (t >= 3) && (t < idle_t);
      check($sformatf("%s clk t=%0d", name, t), 32'(c), 32'(ec));
      check($sformatf("%s valid t=%0d", name, t), 32'(v), 32'(ev));
      check($sformatf("%s active t=%0d", name, t), 32'(a), 32'(ea));
      if (ev) check($sformatf("%s bit t=%0d", name, t), 32'(b), 32'(dat_hist[t-3]));
      if (t == drop_t) begin
        if (sel0) vad0 = 1'b0;
        else      vad  = 1'b0;
      end
      dat_hist[t] = pat[t % 32];
      pdm_data    = dat_hist[t];
    end
  endtask

  initial begin
    // Reset held with vad high: everything stays quiet.
    vad = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst clk", 32'(pclk), 32'd0);
      check("rst valid", 32'(pvalid), 32'd0);
      check("rst bit", 32'(pbit), 32'd0);
      check("rst active", 32'(pact), 32'd0);
      check("rst active0", 32'(pact0), 32'd0);
    end

    // Release; warm-up of 12 cycles, strobes every 4, vad drops at div_cnt=1
    // (t=40) so one more strobe at t=43 and IDLE from t=47.
    rst_n = 1'b1;
    run_seq(1'b0, 52, 40, 47, 19, "run");

    // One-cycle vad glitch: WARMUP at t=3, STOP at t=4, IDLE at t=7; clock high for 2 cycles.
    vad = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step();
      if (t == 1) vad = 1'b0;
      check($sformatf("glitch clk t=%0d", t), 32'(pclk), 32'((t == 3) || (t == 4)));
      check($sformatf("glitch valid t=%0d", t), 32'(pvalid), 32'd0);
      check($sformatf("glitch active t=%0d", t), 32'(pact), 32'((t >= 3) && (t <= 6)));
    end

    // Run up to the first strobe (clock high), then reset asynchronously.
    vad = 1'b1;
    run_seq(1'b0, 19, -1, 1000, 19, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("async rst clk", 32'(pclk), 32'd0);
    check("async rst valid", 32'(pvalid), 32'd0);
    check("async rst active", 32'(pact), 32'd0);
    check("async rst bit", 32'(pbit), 32'd0);
    step();
    rst_n = 1'b1;
    run_seq(1'b0, 24, -1, 1000, 19, "restart");

    // No warm-up: RUN at t=3, first strobe after the first div_cnt==3 at t=7.
    vad0 = 1'b1;
    run_seq(1'b1, 16, -1, 1000, 7, "nowarm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
